// File: rtl/mips_div_pkg.sv
// Shared types and constants for the execute-stage divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: divider FSM state encoding, iteration count, divide-by-zero quotient.
package mips_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DIV_ITERS = 32;

    // Quotient reported for a zero divisor: all ones, no trap.
    localparam logic [31:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Latency: 0 cycles; the caller registers the result.
// Backpressure: none; output follows inputs.
// Ports: rem_i/quo_i = current partial remainder / quotient, dvs_i = divisor
//        magnitude, rem_o/quo_o = state after one shift-and-subtract.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W:0]   rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0]   rem_sh;
    logic [W+1:0] diff;

    // Shift {rem,quo} left by one: the quotient MSB moves into the remainder.
    assign rem_sh = {rem_i[W-1:0], quo_i[W-1]};

    // One extra bit so the borrow of the trial subtraction is visible.
    assign diff = {1'b0, rem_sh} - {2'b00, dvs_i};

    // Restore (keep rem_sh) when the trial subtraction went negative.
    assign rem_o = diff[W+1] ? rem_sh : diff[W:0];
    assign quo_o = {quo_i[W-2:0], ~diff[W+1]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU, producing quotient (lo) and remainder (hi).
// Latency: 33 cycles from acceptance to valid_o (1 cycle for a zero divisor).
// Backpressure: stall_o freezes the pipeline while the divide is in flight; flush_i annuls it.
// Ports: clk/resetn (sync, active low); start_i/signed_i/a_i/b_i request a divide;
//        flush_i kills it; stall_o to hazard logic; valid_o pulses with new hi_o/lo_o.
module div_unit
    import mips_div_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_ITERS,
    parameter int CNT_W     = $clog2(DIV_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [DIV_WIDTH-1:0] a_i,
    input  logic [DIV_WIDTH-1:0] b_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 valid_o,
    output logic [DIV_WIDTH-1:0] hi_o,
    output logic [DIV_WIDTH-1:0] lo_o
);

    div_state_t           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DIV_WIDTH:0]   rem_q;
    logic [DIV_WIDTH-1:0] quo_q;
    logic [DIV_WIDTH-1:0] dvs_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic                 valid_q;
    logic [DIV_WIDTH-1:0] hi_q;
    logic [DIV_WIDTH-1:0] lo_q;

    logic [DIV_WIDTH:0]   rem_d;
    logic [DIV_WIDTH-1:0] quo_d;
    logic [DIV_WIDTH-1:0] lo_res;
    logic [DIV_WIDTH-1:0] hi_res;

    logic                 a_neg;
    logic                 b_neg;
    logic [DIV_WIDTH-1:0] a_mag;
    logic [DIV_WIDTH-1:0] b_mag;

    assign a_neg = signed_i & a_i[DIV_WIDTH-1];
    assign b_neg = signed_i & b_i[DIV_WIDTH-1];
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    div_step #(.W(DIV_WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    // Sign fix-up applied to the final iteration's output as it is registered.
    assign lo_res = neg_quo_q ? -quo_d : quo_d;
    assign hi_res = neg_rem_q ? -rem_d[DIV_WIDTH-1:0] : rem_d[DIV_WIDTH-1:0];

    // Combinational so the pipeline freezes in the same cycle the divide arrives.
    // DONE drops the request so the instruction can leave Execute.
    assign stall_o = resetn & ~flush_i &
                     (((state_q == DIV_IDLE) & start_i) | (state_q == DIV_BUSY));

    assign valid_o = valid_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            valid_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            if (flush_i) begin
                // Annul whatever is in flight; hi/lo keep the last real result.
                state_q <= DIV_IDLE;
            end else begin
                case (state_q)
                    DIV_IDLE: begin
                        if (start_i) begin
                            if (b_i == '0) begin
                                lo_q    <= DIV_WIDTH'(DIV_BY_ZERO_Q);
                                hi_q    <= a_i;
                                valid_q <= 1'b1;
                                state_q <= DIV_DONE;
                            end else begin
                                rem_q     <= '0;
                                quo_q     <= a_mag;
                                dvs_q     <= b_mag;
                                neg_quo_q <= a_neg ^ b_neg;
                                neg_rem_q <= a_neg;
                                cnt_q     <= '0;
                                state_q   <= DIV_BUSY;
                            end
                        end
                    end
                    DIV_BUSY: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DIV_WIDTH - 1)) begin
                            lo_q    <= lo_res;
                            hi_q    <= hi_res;
                            valid_q <= 1'b1;
                            state_q <= DIV_DONE;
                        end
                    end
                    DIV_DONE: begin
                        // start_i here still belongs to the departing instruction.
                        state_q <= DIV_IDLE;
                    end
                    default: begin
                        state_q <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
